// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared widths and response-owner encoding for the memory arbiter
package mem_arbiter_pkg;
  localparam int addr_p = 10;
  localparam int data_width_p = 32;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_e;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, load/store and memory-side signals of the arbiter
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;
  logic                    if_req_i;
  logic [addr_p-1:0]       if_addr_i;
  logic                    if_gnt_o;
  logic                    if_rvalid_o;
  logic [data_width_p-1:0] if_rdata_o;
  logic                    d_req_i;
  logic                    d_we_i;
  logic [addr_p-1:0]       d_addr_i;
  logic [data_width_p-1:0] d_wdata_i;
  logic                    d_gnt_o;
  logic                    d_rvalid_o;
  logic [data_width_p-1:0] d_rdata_o;
  logic [addr_p-1:0]       mem_addr_o;
  logic                    mem_wr_en_o;
  logic                    mem_rd_en_o;
  logic [data_width_p-1:0] mem_wdata_o;
  logic [data_width_p-1:0] mem_rdata_i;
  modport master (
    output if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, mem_rdata_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o,
           mem_addr_o, mem_wr_en_o, mem_rd_en_o, mem_wdata_o
  );
  modport slave (
    input  if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, mem_rdata_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o,
           mem_addr_o, mem_wr_en_o, mem_rd_en_o, mem_wdata_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one synchronous single-port memory between fetch and load/store
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input logic          clk_i,
  input logic          rst_i,
  mem_arbiter_if.slave bus
);
  owner_e last_owner, last_owner_n, resp_owner, resp_owner_n;
  logic if_gnt, d_gnt;
  // Fetch wins unless load/store also asks and fetch owned the previous grant
  always_comb begin
    if_gnt       = !rst_i && bus.if_req_i && (!bus.d_req_i || last_owner == OWN_D);
    d_gnt        = !rst_i && bus.d_req_i && !if_gnt;
    last_owner_n = if_gnt ? OWN_IF : d_gnt ? OWN_D : last_owner;
    resp_owner_n = if_gnt ? OWN_IF : (d_gnt && !bus.d_we_i) ? OWN_D : OWN_NONE;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_owner <= OWN_D;
      resp_owner <= OWN_NONE;
    end else begin
      last_owner <= last_owner_n;
      resp_owner <= resp_owner_n;
    end
  end
  assign bus.if_gnt_o    = if_gnt;
  assign bus.d_gnt_o     = d_gnt;
  assign bus.mem_rd_en_o = if_gnt || (d_gnt && !bus.d_we_i);
  assign bus.mem_wr_en_o = d_gnt && bus.d_we_i;
  assign bus.mem_addr_o  = if_gnt ? bus.if_addr_i : d_gnt ? bus.d_addr_i : '0;
  assign bus.mem_wdata_o = (d_gnt && bus.d_we_i) ? bus.d_wdata_i : '0;
  assign bus.if_rvalid_o = resp_owner == OWN_IF;
  assign bus.d_rvalid_o  = resp_owner == OWN_D;
  assign bus.if_rdata_o  = resp_owner == OWN_IF ? bus.mem_rdata_i : '0;
  assign bus.d_rdata_o   = resp_owner == OWN_D ? bus.mem_rdata_i : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of arbitration, read routing, stores and reset
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [31:0] mem [1024];
  always #5 clk = ~clk;
  mem_arbiter_if bus();
  mem_arbiter dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  // 1024x32 synchronous memory; preloaded with 0x1000_0000|addr while reset is held
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h1000_0000 | 32'(i);
      mem[4] <= 32'hDEAD_BEEF;
      bus.mem_rdata_i <= 32'h0;
    end else begin
      if (bus.mem_wr_en_o) mem[bus.mem_addr_o] <= bus.mem_wdata_o;
      if (bus.mem_rd_en_o) bus.mem_rdata_i <= mem[bus.mem_addr_o];
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic r, input logic ir, input logic [9:0] ia, input logic dr,
                       input logic dw, input logic [9:0] da, input logic [31:0] wd);
    @(posedge clk);
    #1;
    rst = r;
    bus.if_req_i = ir;
    bus.if_addr_i = ia;
    bus.d_req_i = dr;
    bus.d_we_i = dw;
    bus.d_addr_i = da;
    bus.d_wdata_i = wd;
    @(negedge clk);
  endtask
  task automatic idle();
    drive(1'b0, 1'b0, 10'h0, 1'b0, 1'b0, 10'h0, 32'h0);
  endtask
  initial begin
    bus.if_req_i = 1'b1;
    bus.if_addr_i = 10'h020;
    bus.d_req_i = 1'b1;
    bus.d_we_i = 1'b0;
    bus.d_addr_i = 10'h030;
    bus.d_wdata_i = 32'h0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 10'h020, 1'b1, 1'b0, 10'h030, 32'h0);
      chk("rst_if_gnt", 32'(bus.if_gnt_o), 32'h0);
      chk("rst_d_gnt", 32'(bus.d_gnt_o), 32'h0);
      chk("rst_rd_en", 32'(bus.mem_rd_en_o), 32'h0);
      chk("rst_wr_en", 32'(bus.mem_wr_en_o), 32'h0);
      chk("rst_addr", 32'(bus.mem_addr_o), 32'h0);
      chk("rst_rvalid", 32'({bus.if_rvalid_o, bus.d_rvalid_o}), 32'h0);
      chk("rst_rdata", bus.if_rdata_o | bus.d_rdata_o, 32'h0);
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, 10'h020, 1'b1, 1'b0, 10'h030, 32'h0);
      chk("cont_if_gnt", 32'(bus.if_gnt_o), 32'(i % 2 == 0));
      chk("cont_d_gnt", 32'(bus.d_gnt_o), 32'(i % 2 == 1));
      chk("cont_addr", 32'(bus.mem_addr_o), (i % 2 == 0) ? 32'h020 : 32'h030);
      chk("cont_excl", 32'(bus.mem_rd_en_o & bus.mem_wr_en_o), 32'h0);
      if (i > 0) begin
        chk("cont_if_rvalid", 32'(bus.if_rvalid_o), 32'(i % 2 == 1));
        chk("cont_d_rvalid", 32'(bus.d_rvalid_o), 32'(i % 2 == 0));
        chk("cont_if_rdata", bus.if_rdata_o, (i % 2 == 1) ? 32'h1000_0020 : 32'h0);
        chk("cont_d_rdata", bus.d_rdata_o, (i % 2 == 0) ? 32'h1000_0030 : 32'h0);
      end
    end
    idle();
    chk("tail_d_rvalid", 32'(bus.d_rvalid_o), 32'h1);
    chk("tail_d_rdata", bus.d_rdata_o, 32'h1000_0030);
    chk("tail_if_rvalid", 32'(bus.if_rvalid_o), 32'h0);
    chk("tail_gnt", 32'({bus.if_gnt_o, bus.d_gnt_o}), 32'h0);
    drive(1'b0, 1'b1, 10'h004, 1'b0, 1'b0, 10'h0, 32'h0);
    chk("fetch_gnt", 32'(bus.if_gnt_o), 32'h1);
    chk("fetch_d_gnt", 32'(bus.d_gnt_o), 32'h0);
    chk("fetch_addr", 32'(bus.mem_addr_o), 32'h004);
    chk("fetch_rd_en", 32'(bus.mem_rd_en_o), 32'h1);
    idle();
    chk("fetch_rvalid", 32'(bus.if_rvalid_o), 32'h1);
    chk("fetch_rdata", bus.if_rdata_o, 32'hDEAD_BEEF);
    chk("fetch_d_rvalid", 32'(bus.d_rvalid_o), 32'h0);
    drive(1'b0, 1'b0, 10'h0, 1'b1, 1'b1, 10'h3FF, 32'hA5A5_A5A5);
    chk("st_gnt", 32'(bus.d_gnt_o), 32'h1);
    chk("st_wr_en", 32'(bus.mem_wr_en_o), 32'h1);
    chk("st_rd_en", 32'(bus.mem_rd_en_o), 32'h0);
    chk("st_addr", 32'(bus.mem_addr_o), 32'h3FF);
    chk("st_wdata", bus.mem_wdata_o, 32'hA5A5_A5A5);
    drive(1'b0, 1'b0, 10'h0, 1'b1, 1'b0, 10'h3FF, 32'h0);
    chk("ld_gnt", 32'(bus.d_gnt_o), 32'h1);
    chk("ld_rd_en", 32'(bus.mem_rd_en_o), 32'h1);
    chk("ld_wr_en", 32'(bus.mem_wr_en_o), 32'h0);
    chk("st_no_rvalid", 32'(bus.d_rvalid_o), 32'h0);
    chk("ld_wdata_zero", bus.mem_wdata_o, 32'h0);
    idle();
    chk("ld_rvalid", 32'(bus.d_rvalid_o), 32'h1);
    chk("ld_rdata", bus.d_rdata_o, 32'hA5A5_A5A5);
    drive(1'b0, 1'b1, 10'h004, 1'b0, 1'b0, 10'h0, 32'h0);
    chk("mid_gnt", 32'(bus.if_gnt_o), 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_gnt", 32'(bus.if_gnt_o), 32'h0);
    chk("mid_rst_rd_en", 32'(bus.mem_rd_en_o), 32'h0);
    idle();
    chk("mid_rvalid", 32'(bus.if_rvalid_o), 32'h0);
    chk("mid_rdata", bus.if_rdata_o, 32'h0);
    chk("mid_d_rvalid", 32'(bus.d_rvalid_o), 32'h0);
    drive(1'b0, 1'b1, 10'h060, 1'b1, 1'b1, 10'h050, 32'hFFFF_FFFF);
    chk("wd_if_gnt", 32'(bus.if_gnt_o), 32'h1);
    chk("wd_d_gnt", 32'(bus.d_gnt_o), 32'h0);
    chk("wd_wr_en", 32'(bus.mem_wr_en_o), 32'h0);
    idle();
    chk("wd_rdata", bus.if_rdata_o, 32'h1000_0060);
    drive(1'b0, 1'b1, 10'h050, 1'b0, 1'b0, 10'h0, 32'h0);
    chk("wd_rd_gnt", 32'(bus.if_gnt_o), 32'h1);
    idle();
    chk("wd_unchanged", bus.if_rdata_o, 32'h1000_0050);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-port, 1024x32 synchronous memory between the instruction-fetch unit and the load/store unit of the RISC-V core. It accepts one request per cycle, chooses an owner by round-robin on conflict, and drives the memory's address, write-enable, read-enable and write-data inputs. It routes the registered read data (valid one cycle after the access) back to the requester that issued it. It sits between the core front end and back end on one side and the memory block on the other.

## Interface
- addr_p, 10 (riscv_pkg): memory word-address width.
- data_width_p, 32 (riscv_pkg): data width.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- if_req_i  in  1  fetch read request; held with address until granted.
- if_addr_i  in  addr_p  fetch word address.
- if_gnt_o  out  1  fetch request accepted this cycle.
- if_rvalid_o  out  1  fetch read data valid.
- if_rdata_o  out  data_width_p  fetch read data.
- d_req_i  in  1  data request; held with we/addr/wdata until granted.
- d_we_i  in  1  1 = store, 0 = load.
- d_addr_i  in  addr_p  data word address.
- d_wdata_i  in  data_width_p  store data.
- d_gnt_o  out  1  data request accepted this cycle.
- d_rvalid_o  out  1  load data valid.
- d_rdata_o  out  data_width_p  load data.
- mem_addr_o  out  addr_p  to memory address.
- mem_wr_en_o  out  1  to memory write enable.
- mem_rd_en_o  out  1  to memory read enable.
- mem_wdata_o  out  data_width_p  to memory write data.
- mem_rdata_i  in  data_width_p  from memory registered read data.

## Operation
- State: last_owner (IF/D; reset D, so IF wins the first conflict), resp_owner (NONE/IF/D; reset NONE).
- Grant is combinational each cycle when rst_i=0:
  - Only one requester is active: that requester is granted.
  - Both are active: the side that is not last_owner is granted. last_owner then takes the granted side.
  - A single uncontested grant also updates last_owner.
- Granted IF: mem_rd_en_o=1, mem_addr_o=if_addr_i. resp_owner becomes IF.
- Granted D load: mem_rd_en_o=1, mem_addr_o=d_addr_i. resp_owner becomes D.
- Granted D store: mem_wr_en_o=1, mem_addr_o=d_addr_i, mem_wdata_o=d_wdata_i. resp_owner becomes NONE. A store produces no rvalid; it is complete at the grant edge.
- No grant: mem enables are 0, mem_addr_o/mem_wdata_o=0. resp_owner becomes NONE.
- Response: if_rvalid_o=(resp_owner==IF), d_rvalid_o=(resp_owner==D).
  - rdata outputs pass mem_rdata_i through unregistered.
  - rdata outputs are forced to 0 when the matching rvalid is low.
- Requesters must hold req and payload stable until gnt. Dropping req before gnt is legal; no access results.
- Reset mid-operation:
  - rst_i=1 forces all gnt and mem enables to 0 combinationally.
  - The edge with rst_i=1 returns resp_owner to NONE, so any in-flight read response is discarded.
- mem_wr_en_o and mem_rd_en_o are never high together.

## Timing
- Reset values: all gnt, rvalid, rdata, mem_* outputs 0. last_owner=D. resp_owner=NONE.
- Read latency: grant in cycle N, rvalid/rdata in cycle N+1.
- Throughput: one access per cycle with no bubbles. Back-to-back reads from one side produce rvalid every cycle.
- Store at N followed by a load to the same address at N+1: the load returns the new data at N+2.
- Worst-case wait under sustained contention: 1 cycle (strict alternation).
- Paths: gnt depends combinationally on req. The response path from mem_rdata_i to rdata is combinational.

## Structure
- riscv_pkg holds:
  - addr_p and data_width_p (existing);
  - owner_e enum {OWN_NONE, OWN_IF, OWN_D}.
- A single module with no sub-modules.
- The round-robin decision is a small combinational always block feeding the two state registers.

## Test plan
- Reset: hold rst_i=1 for 3 cycles with both req high -> no gnt, mem enables 0, all outputs 0. After release, first-cycle conflict grants IF.
- Lone fetch: if_req_i=1, if_addr_i=0x004, memory preloaded 0xDEADBEEF -> if_gnt_o at N, if_rvalid_o=1 and if_rdata_o=0xDEADBEEF at N+1, d_rvalid_o=0.
- Store then load: D store addr 0x3FF data 0xA5A5A5A5 at N, D load 0x3FF at N+1 -> mem_wr_en_o=1 at N, no rvalid at N+1, d_rdata_o=0xA5A5A5A5 at N+2.
- Contention: both req held for 6 cycles -> grants alternate IF,D,IF,D,IF,D, and each rvalid lands on the correct side one cycle later.
- Reset mid-read: IF granted at N, rst_i=1 during N -> no if_rvalid_o at N+1, resp_owner NONE.
- Withdrawn request: d_req_i pulsed for one cycle while losing arbitration -> no write occurs, memory contents unchanged.
